// File: rtl/mesh_result_collector.sv
// Snapshots per-PE results on start and drains the valid ones in PE order through a
// valid/ready port, flagging missing slots and packets whose address mismatches their slot.
module mesh_result_collector #(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*(WIDTH+1)-1:0]   pe_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     missing_err,
  output logic                     order_err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCapture = 3'd1;
  localparam logic [2:0] StScan    = 3'd2;
  localparam logic [2:0] StEmit    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   CntMax  = (ADDR_WIDTH + 1)'(N);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [WIDTH:0]        snap_q [N];
  logic [WIDTH:0]        snap_d [N];
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  missing_q, missing_d;
  logic                  order_q, order_d;
  logic [WIDTH:0]        cur_slot;

  assign cur_slot = snap_q[index_q];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    snap_d      = snap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    missing_d   = missing_q;
    order_d     = order_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCapture;
          for (int k = 0; k < int'(N); k++) begin
            snap_d[k] = pe_result[k*(WIDTH+1) +: WIDTH+1];
          end
          index_d   = '0;
          count_d   = '0;
          missing_d = 1'b0;
          order_d   = 1'b0;
        end
      end
      StCapture: state_d = StScan;
      StScan: begin
        if (cur_slot[WIDTH]) begin
          state_d     = StEmit;
          out_data_d  = cur_slot[WIDTH-1:0];
          out_valid_d = 1'b1;
        end else begin
          missing_d = 1'b1;
          if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (count_q != CntMax) begin
            count_d = count_q + 1'b1;
          end
          // The address field is the top of the packet; it must name the slot it came from.
          if (out_data_q[WIDTH-1 -: ADDR_WIDTH] != index_q) begin
            order_d = 1'b1;
          end
          out_valid_d = 1'b0;
          if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      missing_q   <= 1'b0;
      order_q     <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      missing_q   <= missing_d;
      order_q     <= order_d;
      snap_q      <= snap_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign missing_err = missing_q;
  assign order_err   = order_q;
  assign busy        = (state_q == StCapture) || (state_q == StScan) || (state_q == StEmit);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_mesh_result_collector.sv
// Scoreboard bench: expected packets are queued when a drain is started and popped by a
// negedge monitor on every accepted handshake.
module tb_mesh_result_collector;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 2;
  localparam int W  = AW + DW;
  localparam int PW = N * (W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] pe_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          missing_err;
  logic          order_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  mesh_result_collector #(
    .N          (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WIDTH      (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pe_result   (pe_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .missing_err (missing_err),
    .order_err   (order_err)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so what the monitor sees here is what the next edge uses.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet got %h expected none", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL packet got %h expected %h", out_data, e);
        end
      end
    end
  end

  function automatic logic [PW-1:0] pe_std();
    logic [PW-1:0] p;
    for (int k = 0; k < N; k++) begin
      p[k*(W+1) +: W+1] = {1'b1, AW'(k), DW'(3 - k)};
    end
    return p;
  endfunction

  // Loads pe_result, pulses start, queues expected packets, checks the CAPTURE cycle.
  task automatic start_drain(input logic [PW-1:0] pe);
    logic [W:0] slot;
    @(posedge clk); #1;
    pe_result = pe;
    start = 1'b1;
    for (int k = 0; k < N; k++) begin
      slot = pe[k*(W+1) +: W+1];
      if (slot[W]) exp_q.push_back(slot[W-1:0]);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 0 || missing_err !== 1'b0 ||
        order_err !== 1'b0) begin
      errors++;
      $display("FAIL capture_state busy=%b done=%b count=%0d miss=%b ord=%b expected 1 0 0 0 0",
               busy, done, count, missing_err, order_err);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout done=%b expected 1", done);
    end
  endtask

  task automatic check_end(input string name, input int exp_cnt, input logic exp_miss,
                           input logic exp_ord);
    checks++;
    if (count !== exp_cnt[AW:0] || missing_err !== exp_miss || order_err !== exp_ord ||
        busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s count=%0d miss=%b ord=%b busy=%b ov=%b left=%0d expected %0d %b %b 0 0 0",
               name, count, missing_err, order_err, busy, out_valid, exp_q.size(),
               exp_cnt, exp_miss, exp_ord);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 0 || busy !== 1'b0 || done !== 1'b0 ||
        count !== 0 || missing_err !== 1'b0 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values ov=%b od=%h busy=%b done=%b cnt=%0d miss=%b ord=%b expected 0",
               out_valid, out_data, busy, done, count, missing_err, order_err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pe_result = pe_std();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 0) begin
        errors++;
        $display("FAIL idle_quiet ov=%b busy=%b done=%b cnt=%0d expected 0 0 0 0",
                 out_valid, busy, done, count);
      end
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    start_drain(pe_std());
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_scan out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h3) begin
      errors++;
      $display("FAIL latency_first ov=%b od=%h expected 1 3", out_valid, out_data);
    end
    wait_done();
    check_end("basic_end", 4, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    start_drain(pe_std());
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h3 || count !== 0) begin
        errors++;
        $display("FAIL stall_%0d ov=%b od=%h cnt=%0d expected 1 3 0", i, out_valid, out_data, count);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done();
    check_end("stall_end", 4, 1'b0, 1'b0);
  endtask

  task automatic test_missing();
    logic [PW-1:0] p;
    p = pe_std();
    p[2*(W+1) + W] = 1'b0;
    start_drain(p);
    wait_done();
    check_end("missing_end", 3, 1'b1, 1'b0);
  endtask

  task automatic test_order();
    logic [PW-1:0] p;
    p = pe_std();
    p[1*(W+1) +: W+1] = {1'b1, 2'd2, 2'd2};
    start_drain(p);
    for (int i = 0; i < 20; i++) begin
      if (count == 1) break;
      @(negedge clk);
    end
    checks++;
    if (order_err !== 1'b0) begin
      errors++;
      $display("FAIL order_early order_err=%b expected 0", order_err);
    end
    wait_done();
    check_end("order_end", 4, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start_drain(pe_std());
    for (int i = 0; i < 20; i++) begin
      if (count == 1) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 0 ||
        out_data !== 0) begin
      errors++;
      $display("FAIL mid_reset ov=%b busy=%b done=%b cnt=%0d od=%h expected 0 0 0 0 0",
               out_valid, busy, done, count, out_data);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    start_drain(pe_std());
    wait_done();
    check_end("after_reset_end", 4, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot_hold();
    start_drain(pe_std());
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pe_result = PW'($urandom);
      start = (i % 2 == 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check_end("snapshot_end", 4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_missing();
    test_order();
    test_reset_mid();
    test_snapshot_hold();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_result_collector.md
MESH_RESULT_COLLECTOR -- requirements
Module: mesh_result_collector

Interface
REQ-001 Parameter N, default 4, number of PEs in the mesh (power of 2, >=2).
REQ-002 Parameter ADDR_WIDTH, default 2, address field width; N = 2^ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 2, data field width.
REQ-004 Parameter WIDTH, default ADDR_WIDTH+DATA_WIDTH, packet width without valid bit.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 start  input  1  one-cycle pulse; snapshot PE results and begin drain.
REQ-008 pe_result  input  N*(WIDTH+1)  flattened per-PE result; slice k = bits [k*(WIDTH+1) +: WIDTH+1] = {valid, addr, data} of PE k.
REQ-009 out_valid  output  1  out_data holds a packet.
REQ-010 out_ready  input  1  downstream accepts packet when out_valid && out_ready.
REQ-011 out_data  output  WIDTH  {addr, data} of current packet.
REQ-012 busy  output  1  high in CAPTURE, SCAN or EMIT.
REQ-013 done  output  1  high in DONE until next start.
REQ-014 count  output  ADDR_WIDTH+1  packets accepted since last start.
REQ-015 missing_err  output  1  sticky: at least one snapshot slot had valid=0.
REQ-016 order_err  output  1  sticky: an emitted packet's addr != its PE index.

Function
REQ-017 States IDLE, CAPTURE, SCAN, EMIT, DONE; reset state IDLE.
REQ-018 IDLE/DONE + start=1 -> CAPTURE next cycle; snapshot register array <= pe_result, index <= 0, count, missing_err, order_err <= 0.
REQ-019 CAPTURE lasts exactly one cycle -> SCAN; pe_result changes after the capture edge have no effect on output.
REQ-020 SCAN, snapshot[index].valid=1 -> EMIT, out_data <= {addr,data} of snapshot[index], out_valid <= 1.
REQ-021 SCAN, snapshot[index].valid=0 -> set missing_err, no packet emitted; index<N-1 -> index+1, stay SCAN; index=N-1 -> DONE.
REQ-022 EMIT: out_valid and out_data stable while out_ready=0 (no timeout).
REQ-023 EMIT, out_ready=1: count+1; order_err set if addr != index[ADDR_WIDTH-1:0]; index<N-1 -> index+1, out_valid<=0, SCAN; index=N-1 -> out_valid<=0, DONE.
REQ-024 Throughput: at most one packet per two cycles (EMIT->SCAN->EMIT); latency start -> first out_valid = 3 cycles when slot 0 valid.
REQ-025 start ignored in CAPTURE, SCAN, EMIT; no restart mid-drain.
REQ-026 out_ready ignored whenever out_valid=0.
REQ-027 count saturates at N; wraps never.
REQ-028 done=1 only in DONE; busy=1 only in CAPTURE/SCAN/EMIT; both 0 in IDLE.
REQ-029 start in DONE clears done on next edge (enters CAPTURE), errors and count cleared as REQ-018.

Reset
REQ-030 rst=0 at any time, including mid-EMIT, asynchronously forces IDLE, out_valid=0, out_data=0, busy=0, done=0, count=0, missing_err=0, order_err=0, index=0, snapshot=0.
REQ-031 After rst deasserts, no output changes until a start pulse.

Verification
REQ-032 N=4, all valid, PE k = {1,k,3-k}, out_ready=1, start -> out_data 0x3,0x6,0x9,0xC (addr,data) in order, count=4, done=1, both errors 0.
REQ-033 Same stimulus, out_ready held 0 for 5 cycles in first EMIT -> out_data=0x3 and out_valid=1 stable all 5 cycles; final count=4.
REQ-034 PE 2 valid=0, others valid -> 3 packets (addrs 0,1,3), count=3, missing_err=1, order_err=0, done=1.
REQ-035 PE 1 result {1,2,x} (address swapped) -> order_err=1 after second acceptance, count=4, drain completes.
REQ-036 rst=0 pulsed during EMIT of second packet -> out_valid, busy, done, count all 0 immediately; subsequent start drains full set correctly.
REQ-037 pe_result changed every cycle after capture; start asserted again while busy -> emitted values equal capture-cycle snapshot, second start has no effect.
